// File: rtl/unary_ramp.sv
// Thermometer-code ramp generator: accepts a target count and steps a registered
// unary vector one code per clock toward it. Optional macro: UNARY_RAMP_COMPLIMENT_EN.
module unary_ramp #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_tgt_vld,
    input  logic [CW-1:0] i_tgt,
    input  logic          i_tgt_cmpl,
    output logic          o_tgt_rdy,
    input  logic          i_abort,
    output logic [W-1:0]  o_x,
    output logic [CW-1:0] o_cnt,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_is_compliment
);

    localparam logic [CW-1:0] MAX_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DN   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic          cmpl_q, cmpl_d;
    logic [W-1:0]  x_q, x_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] tgt_sat;
    logic          accept;

    function automatic logic [W-1:0] therm(input logic [CW-1:0] c);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(W); i++) begin
            r[i] = (CW'(i) < c);
        end
        return r;
    endfunction

    assign o_tgt_rdy = (state_q == S_IDLE) & ~i_abort;
    assign accept    = i_tgt_vld & o_tgt_rdy;
    assign tgt_sat   = (i_tgt > MAX_CNT) ? MAX_CNT : i_tgt;

`ifndef UNARY_RAMP_COMPLIMENT_EN
    logic unused_tgt_cmpl;
    assign unused_tgt_cmpl = i_tgt_cmpl;
`endif

    // Next-state: accept in IDLE, step one code per cycle while ramping, abort holds code
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        cmpl_d  = cmpl_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tgt_d = tgt_sat;
`ifdef UNARY_RAMP_COMPLIMENT_EN
                    cmpl_d = i_tgt_cmpl;
`endif
                    if (tgt_sat > cnt_q) begin
                        state_d = S_UP;
                    end else if (tgt_sat < cnt_q) begin
                        state_d = S_DN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_UP: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == tgt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DN: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_d == tgt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        x_d    = therm(cnt_d) ^ {W{cmpl_d}};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            cmpl_q  <= 1'b0;
            x_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            cmpl_q  <= cmpl_d;
            x_q     <= x_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_x             = x_q;
    assign o_cnt           = cnt_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_is_compliment = cmpl_q;

endmodule
